// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of the shared ALU: grants one requester at a time,
// registers its operands onto the ALU, returns the result with the requester ID and owns NZCV.
module alu_issue_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_opcode,
    input  logic [4*NREQ-1:0]    req_cond,
    input  logic [NREQ-1:0]      req_s,
    input  logic [3*NREQ-1:0]    req_sr_cont,
    input  logic [5*NREQ-1:0]    req_sr_bit,
    input  logic [16*NREQ-1:0]   req_imm,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [3:0]           alu_opcode,
    output logic [3:0]           alu_cond,
    output logic                 alu_s,
    output logic [2:0]           alu_sr_cont,
    output logic [4:0]           alu_sr_bit,
    output logic [15:0]          alu_imm,
    output logic [31:0]          alu_in1,
    output logic [31:0]          alu_in2,
    input  logic [31:0]          alu_out,
    input  logic [3:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic [3:0]           flags_q
);

    localparam logic [3:0] OP_CMP = 4'b1011;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e         state_q;
    state_e         state_d;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_vld;
    int             scan_idx;
    int             gsel;
    logic [3:0]     sel_op;
    logic           sel_illegal;

    // Round-robin scan starting just after the previous winner
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            scan_idx = (int'(last_grant) + k) % int'(NREQ);
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(scan_idx);
            end
        end
    end

    assign gsel   = int'(grant_idx);
    assign sel_op = req_opcode[4*gsel +: 4];

    // Opcodes with no ALU implementation bypass EXEC and answer with an error
    always_comb begin
        case (sel_op)
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1111: sel_illegal = 1'b1;
            default:                                     sel_illegal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    state_d = sel_illegal ? RESP : EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Issue registers, response capture and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= IDW'(NREQ - 1);
            alu_opcode  <= '0;
            alu_cond    <= '0;
            alu_s       <= 1'b0;
            alu_sr_cont <= '0;
            alu_sr_bit  <= '0;
            alu_imm     <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            flags_q     <= '0;
        end else begin
            rsp_valid <= (state_d == RESP);
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        last_grant <= grant_idx;
                        if (sel_illegal) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                            rsp_id   <= grant_idx;
                        end else begin
                            alu_opcode  <= sel_op;
                            alu_cond    <= req_cond[4*gsel +: 4];
                            alu_s       <= req_s[gsel];
                            alu_sr_cont <= req_sr_cont[3*gsel +: 3];
                            alu_sr_bit  <= req_sr_bit[5*gsel +: 5];
                            alu_imm     <= req_imm[16*gsel +: 16];
                            alu_in1     <= req_a[32*gsel +: 32];
                            alu_in2     <= req_b[32*gsel +: 32];
                        end
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    rsp_err  <= 1'b0;
                    rsp_id   <= last_grant;
                    // CMP exists only to set flags, so it updates them regardless of S
                    if (alu_s || alu_opcode == OP_CMP) flags_q <= alu_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with two requesters and a small ADD/CMP ALU model.
module tb_alu_issue_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_opcode;
    logic [4*NREQ-1:0]   req_cond;
    logic [NREQ-1:0]     req_s;
    logic [3*NREQ-1:0]   req_sr_cont;
    logic [5*NREQ-1:0]   req_sr_bit;
    logic [16*NREQ-1:0]  req_imm;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [3:0]          alu_opcode;
    logic [3:0]          alu_cond;
    logic                alu_s;
    logic [2:0]          alu_sr_cont;
    logic [4:0]          alu_sr_bit;
    logic [15:0]         alu_imm;
    logic [31:0]         alu_in1;
    logic [31:0]         alu_in2;
    logic [31:0]         alu_out;
    logic [3:0]          alu_flags;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic [3:0]          flags_q;

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_cond(req_cond), .req_s(req_s),
        .req_sr_cont(req_sr_cont), .req_sr_bit(req_sr_bit), .req_imm(req_imm),
        .req_a(req_a), .req_b(req_b),
        .alu_opcode(alu_opcode), .alu_cond(alu_cond), .alu_s(alu_s),
        .alu_sr_cont(alu_sr_cont), .alu_sr_bit(alu_sr_bit), .alu_imm(alu_imm),
        .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // ALU stand-in: ADD and CMP (subtract, C = no borrow); anything else XORs with zero flags
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum   = '0;
        alu_out   = alu_in1 ^ alu_in2;
        alu_flags = 4'b0000;
        if (alu_opcode == 4'b0000) begin
            alu_sum   = {1'b0, alu_in1} + {1'b0, alu_in2};
            alu_out   = alu_sum[31:0];
            alu_flags = {alu_sum[31], alu_sum[31:0] == 32'd0, alu_sum[32],
                         (alu_in1[31] == alu_in2[31]) && (alu_sum[31] != alu_in1[31])};
        end else if (alu_opcode == 4'b1011) begin
            alu_sum   = {1'b0, alu_in1} + {1'b0, ~alu_in2} + 33'd1;
            alu_out   = alu_sum[31:0];
            alu_flags = {alu_sum[31], alu_sum[31:0] == 32'd0, alu_sum[32],
                         (alu_in1[31] != alu_in2[31]) && (alu_sum[31] != alu_in1[31])};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        req_opcode[4*i +: 4]   = op;
        req_cond[4*i +: 4]     = 4'hE;
        req_s[i]               = s;
        req_sr_cont[3*i +: 3]  = 3'(i + 1);
        req_sr_bit[5*i +: 5]   = 5'(i + 3);
        req_imm[16*i +: 16]    = 16'(16'hA0 + i);
        req_a[32*i +: 32]      = a;
        req_b[32*i +: 32]      = b;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '0;
        req_opcode = '0; req_cond = '0; req_s = '0; req_sr_cont = '0;
        req_sr_bit = '0; req_imm = '0; req_a = '0; req_b = '0;
        #12;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp", 64'({rsp_id, rsp_err, rsp_data}), 64'd0);
        check("rst_flags", 64'(flags_q), 64'd0);
        check("rst_issue", 64'({alu_opcode, alu_cond, alu_s, alu_sr_cont, alu_sr_bit, alu_imm}), 64'd0);
        check("rst_operands", {alu_in1, alu_in2}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // R0 ADD 5+7 with S
        set_req(0, 4'b0000, 1'b1, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        check("add_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        check("add_exec_no_rsp", 64'(rsp_valid), 64'd0);
        check("add_issue_ops", {alu_in1, alu_in2}, {32'd5, 32'd7});
        check("add_issue_ctl", 64'({alu_cond, alu_s, alu_sr_cont, alu_sr_bit, alu_imm}),
              64'({4'hE, 1'b1, 3'd1, 5'd3, 16'hA0}));
        check("add_exec_ready", 64'(req_ready), 64'd0);
        tick();
        check("add_rsp", 64'({rsp_valid, rsp_err, rsp_id, rsp_data}), 64'({1'b1, 1'b0, 1'b0, 32'd12}));
        check("add_flags", 64'(flags_q), 64'd0);
        tick();
        check("add_rsp_drop", 64'(rsp_valid), 64'd0);

        // R1 CMP 3,3 without S still sets flags
        set_req(1, 4'b1011, 1'b0, 32'd3, 32'd3);
        req_valid = 2'b10;
        #1;
        check("cmp_ready", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        tick();
        check("cmp_rsp", 64'({rsp_valid, rsp_err, rsp_id, rsp_data}), 64'({1'b1, 1'b0, 1'b1, 32'd0}));
        check("cmp_flags", 64'(flags_q), 64'b0110);
        tick();

        // R0 ADD without S leaves flags alone
        set_req(0, 4'b0000, 1'b0, 32'd1, 32'd2);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check("adds0_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 1'b0, 32'd3}));
        check("adds0_flags", 64'(flags_q), 64'b0110);
        tick();

        // Illegal opcode answers one cycle after grant with an error
        set_req(0, 4'b1111, 1'b1, 32'd9, 32'd9);
        req_valid = 2'b01;
        #1;
        check("ill_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        check("ill_rsp", 64'({rsp_valid, rsp_err, rsp_id, rsp_data}), 64'({1'b1, 1'b1, 1'b0, 32'd0}));
        check("ill_flags", 64'(flags_q), 64'b0110);
        check("ill_no_issue", 64'({alu_opcode, alu_in1}), 64'({4'b0000, 32'd1}));
        tick();

        // Both requesters held valid: grants alternate every 3 cycles
        set_req(0, 4'b0000, 1'b0, 32'd10, 32'd1);
        set_req(1, 4'b0000, 1'b0, 32'd20, 32'd2);
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1;
            check($sformatf("rr_ready_%0d", n), 64'(req_ready), (n % 2 == 0) ? 64'b10 : 64'b01);
            tick();
            tick();
            check($sformatf("rr_rsp_%0d", n), 64'({rsp_valid, rsp_id, rsp_data}),
                  (n % 2 == 0) ? 64'({1'b1, 1'b1, 32'd22}) : 64'({1'b1, 1'b0, 32'd11}));
            tick();
        end

        // Response back-pressure with R1 waiting
        rsp_ready = 1'b0;
        set_req(0, 4'b0000, 1'b0, 32'd100, 32'd1);
        req_valid = 2'b01;
        #1;
        check("bp_grant0", 64'(req_ready), 64'b01);
        tick();
        set_req(1, 4'b0000, 1'b0, 32'd7, 32'd8);
        req_valid = 2'b10;
        #1;
        check("bp_exec_ready", 64'(req_ready), 64'd0);
        tick();
        for (int n = 0; n < 5; n++) begin
            check($sformatf("bp_hold_%0d", n), 64'({req_ready, rsp_valid, rsp_err, rsp_id, rsp_data}),
                  64'({2'b00, 1'b1, 1'b0, 1'b0, 32'd101}));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_grant1", 64'({rsp_valid, req_ready}), 64'({1'b0, 2'b10}));
        tick();
        req_valid = 2'b00;
        tick();
        check("bp_rsp1", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 1'b1, 32'd15}));
        tick();

        // Reset while R1 is in EXEC
        set_req(1, 4'b0000, 1'b1, 32'd2, 32'd3);
        req_valid = 2'b10;
        #1;
        check("mid_grant1", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check("mid_rst", 64'({rsp_valid, flags_q, alu_in1}), 64'd0);
        rst_n = 1'b1;
        set_req(0, 4'b0000, 1'b0, 32'd4, 32'd4);
        req_valid = 2'b11;
        #1;
        check("mid_next_grant", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        tick();
        check("mid_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 1'b0, 32'd8}));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
